// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared branch-resolution record and BHT entry types
package ariane_pkg;
   typedef enum logic [2:0] {
      NoCF   = 3'd0,
      Branch = 3'd1,
      Jump   = 3'd2,
      JumpR  = 3'd3,
      Return = 3'd4
   } cf_t;

   typedef struct packed {
      logic                   valid;
      logic [riscv::VLEN-1:0] pc;
      logic [riscv::VLEN-1:0] target_address;
      logic                   is_mispredict;
      logic                   is_taken;
      cf_t                    cf_type;
   } bp_resolve_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] saturation_counter;
   } bht_entry_t;

   localparam logic [1:0] BHT_CTR_INIT = 2'b01;
endpackage

// File: rtl/bht_predict_table_pkg.sv
// rtl/bht_predict_table_pkg.sv - BHT sweep FSM states and statistics width
package bht_predict_table_pkg;
   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_IDLE  = 1'b1
   } bht_state_e;

   localparam int unsigned STAT_W = 32;
endpackage

// File: rtl/riscv.sv
// rtl/riscv.sv - RISC-V architectural widths used by the branch predictor
package riscv;
   localparam int unsigned VLEN = 64;
endpackage

// File: rtl/bht_predict_table_sat_counter.sv
// rtl/bht_predict_table_sat_counter.sv - next 2-bit saturating counter for one BHT entry
module bht_sat_counter
   import ariane_pkg::*;
(
   input  logic       i_valid,
   input  logic [1:0] i_ctr,
   input  logic       i_taken,
   output logic [1:0] o_ctr
);
   // A fresh entry starts on the weak side matching the first observed outcome.
   always_comb begin
      o_ctr = i_ctr;
      if (!i_valid) begin
         o_ctr = i_taken ? 2'b10 : BHT_CTR_INIT;
      end else if (i_taken && (i_ctr != 2'b11)) begin
         o_ctr = i_ctr + 2'd1;
      end else if (!i_taken && (i_ctr != 2'b00)) begin
         o_ctr = i_ctr - 2'd1;
      end
   end
endmodule

// File: rtl/bht_predict_table.sv
// rtl/bht_predict_table.sv - branch history table with sweep init/flush and registered lookup
// Optional training statistics counters enabled by BHT_STATS_EN.
module bht_predict_table
   import ariane_pkg::*;
   import bht_predict_table_pkg::*;
#(
   parameter int unsigned NR_ENTRIES = 1024,
   parameter int unsigned ROW_OFFSET = 1
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_bp_i,
   input  logic                   debug_mode_i,
   input  logic                   lookup_valid_i,
   input  logic [riscv::VLEN-1:0] lookup_pc_i,
   output logic                   pred_valid_o,
   output logic                   pred_taken_o,
   input  bp_resolve_t            resolved_branch_i,
   output logic                   ready_o,
   output logic [STAT_W-1:0]      stat_updates_o,
   output logic [STAT_W-1:0]      stat_mispredicts_o
);
   localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

   bht_state_e       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
   bht_entry_t       r_table [NR_ENTRIES];

   logic             r_upd_valid, r_upd_taken, r_upd_mispredict;
   logic [IDX_W-1:0] r_upd_idx;
   logic             r_pred_valid, r_pred_taken;

   logic             w_capture, w_wr_en, w_lookup_en, w_bypass;
   logic [IDX_W-1:0] w_lookup_idx, w_res_idx;
   bht_entry_t       w_wr_old, w_lookup_ent;
   logic [1:0]       w_wr_ctr;
   logic             w_unused;

   assign ready_o      = (r_state == ST_IDLE);
   assign w_lookup_idx = lookup_pc_i[ROW_OFFSET +: IDX_W];
   assign w_res_idx    = resolved_branch_i.pc[ROW_OFFSET +: IDX_W];

   // A flush in either the capture or the write cycle discards the update.
   assign w_capture = resolved_branch_i.valid && (resolved_branch_i.cf_type == Branch)
                      && !debug_mode_i && ready_o && !flush_bp_i;
   assign w_wr_en   = r_upd_valid && ready_o && !flush_bp_i && !rst_i;
   assign w_wr_old  = r_table[r_upd_idx];

   bht_sat_counter u_sat_counter (
      .i_valid (w_wr_old.valid),
      .i_ctr   (w_wr_old.saturation_counter),
      .i_taken (r_upd_taken),
      .o_ctr   (w_wr_ctr)
   );

   assign w_lookup_en  = lookup_valid_i && ready_o;
   assign w_lookup_ent = r_table[w_lookup_idx];
   assign w_bypass     = w_wr_en && (r_upd_idx == w_lookup_idx);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      if (flush_bp_i) begin
         w_state_nxt = ST_SWEEP;
         w_ptr_nxt   = '0;
      end else if (r_state == ST_SWEEP) begin
         w_ptr_nxt = r_ptr + IDX_W'(1);
         if (r_ptr == LAST_IDX) begin
            w_state_nxt = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_SWEEP;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (r_state == ST_SWEEP) begin
         r_table[r_ptr] <= '{valid: 1'b0, saturation_counter: BHT_CTR_INIT};
      end else if (w_wr_en) begin
         r_table[r_upd_idx] <= '{valid: 1'b1, saturation_counter: w_wr_ctr};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_upd_valid      <= 1'b0;
         r_upd_idx        <= '0;
         r_upd_taken      <= 1'b0;
         r_upd_mispredict <= 1'b0;
         r_pred_valid     <= 1'b0;
         r_pred_taken     <= 1'b0;
      end else begin
         r_upd_valid <= w_capture;
         if (w_capture) begin
            r_upd_idx        <= w_res_idx;
            r_upd_taken      <= resolved_branch_i.is_taken;
            r_upd_mispredict <= resolved_branch_i.is_mispredict;
         end
         r_pred_valid <= w_lookup_en && (w_bypass || w_lookup_ent.valid);
         r_pred_taken <= w_lookup_en &&
                         (w_bypass ? w_wr_ctr[1] : w_lookup_ent.saturation_counter[1]);
      end
   end

   assign pred_valid_o = r_pred_valid;
   assign pred_taken_o = r_pred_taken;

`ifdef BHT_STATS_EN
   logic [STAT_W-1:0] r_stat_updates, r_stat_mispredicts;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stat_updates     <= '0;
         r_stat_mispredicts <= '0;
      end else if (w_wr_en) begin
         r_stat_updates <= r_stat_updates + STAT_W'(1);
         if (r_upd_mispredict) begin
            r_stat_mispredicts <= r_stat_mispredicts + STAT_W'(1);
         end
      end
   end

   assign stat_updates_o     = r_stat_updates;
   assign stat_mispredicts_o = r_stat_mispredicts;
`else
   assign stat_updates_o     = '0;
   assign stat_mispredicts_o = '0;
`endif

   // Upper PC bits and the target address play no part in direction prediction.
   assign w_unused = ^{lookup_pc_i, resolved_branch_i, r_upd_mispredict};
endmodule

// File: doc/bht_predict_table.md
Name: bht_predict_table

Overview:
- Branch history table downstream of the branch unit. Consumes its resolved-branch record (ariane_pkg::bp_resolve_t) and trains per-entry 2-bit saturating counters.
- Answers conditional-branch direction lookups from the frontend with one-cycle registered latency.
- A sweep FSM initialises or flushes the table, one entry per cycle, after reset or on flush_bp_i.

Parameters:
- NR_ENTRIES, 1024, number of table entries; power of two, at least 4.
- ROW_OFFSET, 1, low PC bits dropped before indexing (halfword granularity for compressed instructions).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_bp_i  in  1  request a full table flush.
- debug_mode_i  in  1  when high, training is suppressed.
- lookup_valid_i  in  1  lookup request.
- lookup_pc_i  in  riscv::VLEN  PC of the branch being predicted.
- pred_valid_o  out  1  registered: the prediction is meaningful.
- pred_taken_o  out  1  registered: predicted taken (counter MSB).
- resolved_branch_i  in  ariane_pkg::bp_resolve_t  resolution record from the branch unit.
- ready_o  out  1  high when the table is in IDLE (not sweeping).
- stat_updates_o  out  32  number of training writes (see Optional Feature).
- stat_mispredicts_o  out  32  number of trained mispredicts (see Optional Feature).

Behaviour:
- Index: IDX_W = $clog2(NR_ENTRIES); index = pc[ROW_OFFSET+IDX_W-1:ROW_OFFSET]. Upper PC bits are ignored, so aliasing is allowed.
- Entry: valid bit plus 2-bit counter. Counter values: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- FSM states:
  - SWEEP: ptr counts 0..NR_ENTRIES-1. Each cycle writes entry[ptr] = {valid 0, counter 01}. After ptr = NR_ENTRIES-1 the FSM moves to IDLE, so a sweep lasts exactly NR_ENTRIES cycles.
  - IDLE: normal operation.
- Reset: rst_i forces SWEEP with ptr = 0, whether or not a sweep is already running. Outputs during reset: pred_valid_o = 0, pred_taken_o = 0, ready_o = 0, stat counters = 0.
- Flush:
  - flush_bp_i in IDLE: SWEEP with ptr = 0 from the next cycle.
  - flush_bp_i during SWEEP: restarts ptr at 0.
  - flush_bp_i and rst_i together: reset wins (same outcome).
- ready_o = (state == IDLE).
- Lookup:
  - Cycle t: lookup_valid_i with ready_o high.
  - Cycle t+1: pred_valid_o = entry.valid, pred_taken_o = counter[1].
  - Otherwise at t+1: pred_valid_o = 0 and pred_taken_o = 0.
  - Lookups during SWEEP always return pred_valid_o = 0.
- Training, two stages:
  - Capture (cycle t): register the record when resolved_branch_i.valid && cf_type == ariane_pkg::Branch && !debug_mode_i && ready_o.
  - Write (cycle t+1): read entry[idx(pc)] and write it back with valid = 1.
    - New entry (valid was 0): counter = is_taken ? 10 : 01.
    - Existing entry: counter saturates up when is_taken, down otherwise; 11 stays 11, 00 stays 00.
  - Non-Branch cf_type records are ignored.
- Hazards:
  - Lookup at the same index in the write cycle: the prediction reflects the newly written value (write-first bypass).
  - Back-to-back updates to the same index in consecutive cycles: the second update uses the first one's result.
  - A flush or reset arriving while a captured update is pending drops that update; the sweep wins.
- A write to an index that the sweep has already passed is not possible, because captures require ready_o high.

Optional Feature:
- Macro: BHT_STATS_EN.
- Defined:
  - stat_updates_o increments on every write-stage write.
  - stat_mispredicts_o increments when the captured record has is_mispredict = 1.
  - Both counters wrap modulo 2^32, clear on rst_i only, and are not cleared by flush.
- Not defined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package (ariane_pkg): bht_entry_t {valid; saturation_counter[1:0]}, and the constant BHT_CTR_INIT = 2'b01.
- bp_resolve_t and the Branch cf_type are reused from ariane_pkg unchanged.
- Sub-module bht_sat_counter: combinational next-counter logic from (valid, counter, taken).

Test Plan:
- Reset with NR_ENTRIES = 16: ready_o stays 0 for 16 cycles, then goes 1. A lookup at pc 0x100 then gives pred_valid_o = 0 one cycle later.
- Three Branch records at pc 0x80, is_taken = 1, each 1 cycle apart; then a lookup at 0x80: pred_valid_o = 1, pred_taken_o = 1, counter 11. Then two not-taken records: counter 01, pred_taken_o = 0.
- Update to pc 0x40 at cycle t with a lookup of 0x40 at t+1 (the write cycle): the response at t+2 shows valid = 1, taken = 1 (bypass).
- flush_bp_i asserted mid-operation while an update is pending: ready_o drops and the update is lost. After NR_ENTRIES cycles all lookups give pred_valid_o = 0.
- A JumpR record, and a Branch record with debug_mode_i = 1: the table is unchanged and stat_updates_o does not increment (BHT_STATS_EN defined).
- With BHT_STATS_EN, 5 updates of which 2 are mispredicts: stat_updates_o = 5, stat_mispredicts_o = 2. A flush keeps the counts; rst_i clears them to 0.
